// File: rtl/video_sync_pkg.sv
// Shared types, phase encodings and default 640x480 timing for the raster sync generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_sync_pkg;

  // Default 640x480@60 timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Generic phase encoding used by the axis counter; matches both enums below
  localparam logic [1:0] AX_ACT = 2'd0;
  localparam logic [1:0] AX_FPO = 2'd1;
  localparam logic [1:0] AX_SYN = 2'd2;
  localparam logic [1:0] AX_BPO = 2'd3;

  typedef enum logic [1:0] {
    H_ACT = 2'd0,
    H_FPO = 2'd1,
    H_SYN = 2'd2,
    H_BPO = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACT = 2'd0,
    V_FPO = 2'd1,
    V_SYN = 2'd2,
    V_BPO = 2'd3
  } v_state_t;

  // Map an asserted/deasserted sync onto the pin level for the given polarity
  function automatic logic sync_level(input logic active, input logic pol);
    return ~(active ^ pol);
  endfunction

endpackage

// File: rtl/video_sync_gen_axis.sv
// One raster axis: wrapping position counter plus the ACT/FPO/SYN/BPO phase register.
// Latency: count and phase update on the same edge as advance; tc is combinational.
// Backpressure: none; advances only when adv is high, otherwise holds.
module sync_axis_counter
  import video_sync_pkg::*;
#(
  parameter int W   = 11,
  parameter int ACT = DEF_H_ACTIVE,
  parameter int FP  = DEF_H_FP,
  parameter int SYN = DEF_H_SYNC,
  parameter int BP  = DEF_H_BP
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic [1:0]   phase,
  output logic         tc
);

  // Phase boundaries compared at W+1 bits so a boundary equal to 2^W cannot alias to 0
  localparam logic [W:0] E_FPO = (W+1)'(ACT);
  localparam logic [W:0] E_SYN = (W+1)'(ACT + FP);
  localparam logic [W:0] E_BPO = (W+1)'(ACT + FP + SYN);

  logic [W-1:0] cnt_nxt;
  logic         at_last;

  // Phase is a pure function of position; zero-width phases are skipped naturally.
  // Positions past the nominal total (interlace extra line) fall into BPO.
  function automatic logic [1:0] phase_of(input logic [W-1:0] c);
    logic [W:0] cx;
    cx = {1'b0, c};
    if (cx < E_FPO)      return AX_ACT;
    else if (cx < E_SYN) return AX_FPO;
    else if (cx < E_BPO) return AX_SYN;
    else                 return AX_BPO;
  endfunction

  assign at_last = (cnt == last);
  assign tc      = adv && at_last;
  assign cnt_nxt = at_last ? '0 : cnt + 1'b1;

  // Advance position and phase together so phase always describes cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= phase_of('0);
    end else if (adv) begin
      cnt   <= cnt_nxt;
      phase <= phase_of(cnt_nxt);
    end
  end

endmodule

// File: rtl/video_sync_gen.sv
// Raster sync generator: h/v counters, syncs, blanking, clear strobes, optional 2:1 interlace.
// Latency: every output is a registered decode, one enabled cycle behind the internal counters.
// Backpressure: en low freezes all state; strobes drop to 0 while en is low.
module video_sync_gen
  import video_sync_pkg::*;
#(
  parameter int HW       = 11,
  parameter int VW       = 10,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          interlace,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          cblank,
  output logic          active,
  output logic          pclr,
  output logic          cclr,
  output logic          frame_start,
  output logic          field,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The interlaced field needs one extra line, hence V_TOTAL+1 must fit
  if (H_TOTAL > (1 << HW)) begin : g_h_width_check
    $error("video_sync_gen: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL + 1 > (1 << VW)) begin : g_v_width_check
    $error("video_sync_gen: V_TOTAL+1 does not fit in VW bits");
  end

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_HALF   = HW'(H_TOTAL / 2);
  localparam logic [VW-1:0] V_LAST_P = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST_I = VW'(V_TOTAL);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam bit            HAS_VS   = (V_SYNC > 0);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    h_ph;
  logic [1:0]    v_ph;
  logic          h_tc;
  logic          v_tc;
  logic [VW-1:0] vlast;
  h_state_t      hstate;
  v_state_t      vstate;

  logic          ilace_q;
  logic          field_q;
  logic          odd_field;

  logic          hs_act;
  logic          vs_act;
  logic          visible;
  logic          at_origin;

  assign hstate    = h_state_t'(h_ph);
  assign vstate    = v_state_t'(v_ph);
  assign odd_field = field_q && ilace_q;
  assign vlast     = odd_field ? V_LAST_I : V_LAST_P;

  sync_axis_counter #(
    .W   (HW),
    .ACT (H_ACTIVE),
    .FP  (H_FP),
    .SYN (H_SYNC),
    .BP  (H_BP)
  ) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (en),
    .last  (H_LAST),
    .cnt   (hcnt),
    .phase (h_ph),
    .tc    (h_tc)
  );

  // Vertical axis steps once per horizontal wrap
  sync_axis_counter #(
    .W   (VW),
    .ACT (V_ACTIVE),
    .FP  (V_FP),
    .SYN (V_SYNC),
    .BP  (V_BP)
  ) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (h_tc),
    .last  (vlast),
    .cnt   (vcnt),
    .phase (v_ph),
    .tc    (v_tc)
  );

  // Interlace request and field parity only change at a field wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ilace_q <= 1'b0;
      field_q <= 1'b0;
    end else if (v_tc) begin
      ilace_q <= interlace;
      field_q <= interlace ? ~field_q : 1'b0;
    end
  end

  // Decode sync/blank from current counter state; odd field shifts vsync by half a line
  always_comb begin
    hs_act    = (hstate == H_SYN);
    vs_act    = (vstate == V_SYN);
    visible   = (hstate == H_ACT) && (vstate == V_ACT);
    at_origin = (hcnt == '0) && (vcnt == '0);
    if (odd_field) begin
      vs_act = ((vstate == V_SYN) && !((vcnt == VS_START) && (hcnt < H_HALF))) ||
               (HAS_VS && (vcnt == VS_END) && (hcnt < H_HALF));
    end
  end

  // Register the decode; on disabled cycles hold levels and squash strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      csync       <= ~SYNC_POL;
      cblank      <= 1'b1;
      active      <= 1'b0;
      pclr        <= 1'b0;
      cclr        <= 1'b0;
      frame_start <= 1'b0;
      field       <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else if (en) begin
      hsync       <= sync_level(hs_act, SYNC_POL);
      vsync       <= sync_level(vs_act, SYNC_POL);
      csync       <= sync_level(hs_act ^ vs_act, SYNC_POL);
      cblank      <= ~visible;
      active      <= visible;
      pclr        <= h_tc;
      cclr        <= v_tc;
      frame_start <= at_origin;
      field       <= field_q;
      x           <= hcnt;
      y           <= vcnt;
    end else begin
      pclr        <= 1'b0;
      cclr        <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/video_sync_gen.md
# video_sync_gen

Parametrised raster sync generator for the video path. It owns its own pixel and line counters and is the successor to the fixed-state sync controller that depended on external counter terminal-count strobes. It produces registered hsync, vsync, csync and cblank, plus the counter-clear strobes, from programmable porch and sync widths, and adds optional 2:1 interlace. It sits between the pixel clock domain and the frame-buffer read logic, which consumes `x`, `y`, `active` and `frame_start`.

## Interface
- `HW`, 11: pixel counter width.
- `VW`, 10: line counter width.
- `H_ACTIVE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines per field.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync polarity; 0 means sync is active-low, 1 means active-high.
- `clk` in 1: pixel clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: pixel enable; when low, all state holds.
- `interlace` in 1: interlace mode request; sampled only at frame wrap.
- `hsync` out 1: horizontal sync, at `SYNC_POL` polarity.
- `vsync` out 1: vertical sync, at `SYNC_POL` polarity.
- `csync` out 1: composite sync, at `SYNC_POL` polarity.
- `cblank` out 1: blanking; 1 outside the active area.
- `active` out 1: the inverse of `cblank`.
- `pclr` out 1: one-cycle strobe on the last pixel of a line.
- `cclr` out 1: one-cycle strobe on the last pixel of the last line of a field.
- `frame_start` out 1: one-cycle strobe at (0,0).
- `field` out 1: current field; always 0 in progressive mode.
- `x` out HW: pixel position, aligned with the sync outputs.
- `y` out VW: line position, aligned with the sync outputs.

## Operation
- Derived totals: `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP`, `V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP`.
- Elaboration must fail if `H_TOTAL` exceeds 2^HW or `V_TOTAL+1` exceeds 2^VW.
- Horizontal FSM `H_ACT → H_FPO → H_SYN → H_BPO → H_ACT`.
  - Each state lasts its parameter count of enabled cycles.
  - `hcnt` counts 0 to `H_TOTAL-1`, then wraps to 0.
- Vertical FSM `V_ACT → V_FPO → V_SYN → V_BPO → V_ACT`.
  - It advances only on a horizontal wrap.
  - `vcnt` counts 0 to `vlast`, then wraps to 0.
  - `vlast` is `V_TOTAL-1`, or `V_TOTAL` when `field=1` and interlace is latched.
- Interlace:
  - `ilace_q` latches `interlace` only on a field wrap.
  - When `ilace_q=1`, `field` toggles on each field wrap.
  - When `ilace_q=0`, `field` is forced to 0.
- Field 1 in interlace mode:
  - vsync asserts and deasserts at `hcnt = H_TOTAL/2` (integer division) instead of at `hcnt = 0`.
  - The extra line belongs to `V_BPO`.
- Output decode:
  - `cblank = !(H_ACT && V_ACT)`.
  - `csync` is asserted when exactly one of hsync or vsync is asserted, i.e. the logical XOR of the two active-level signals, then driven at `SYNC_POL` polarity.
- `en=0`: counters, FSMs and all outputs hold their values, and strobes are forced to 0.
- `interlace` changing mid-field has no effect until the next field wrap.

## Timing
- Reset values:
  - `hcnt`, `vcnt`, `x`, `y`, `field` and `ilace_q` are 0.
  - FSMs are in `H_ACT` / `V_ACT`.
  - `hsync`, `vsync` and `csync` are inactive (equal to `!SYNC_POL`).
  - `cblank` is 1 and `active` is 0.
  - `pclr`, `cclr` and `frame_start` are 0.
- All outputs are registered decodes of the counter state.
  - They lag the internal counters by exactly one enabled cycle.
  - `x`/`y` are the registered copy, so they stay coherent with the sync outputs.
- First enabled edge after reset: outputs show `x=0`, `y=0`, `cblank=0`, `frame_start=1`.
- `pclr` and `cclr` coincide with `x = H_TOTAL-1`. `cclr` implies `pclr`.
- Reset asserted mid-line: all outputs go to their reset values asynchronously, with no glitch-dependent behaviour on release.
- `H_SYNC=1` or `V_SYNC=1` are legal and give a single-cycle (or single-line) pulse.
- Any zero-width porch skips that FSM state.

## Structure
- Package `video_sync_pkg` holds:
  - the `h_state_t` and `v_state_t` enums;
  - the `sync_level(active, pol)` function;
  - the default timing constants for 640x480.
- Sub-module `sync_axis_counter`, instantiated twice (horizontal and vertical), provides:
  - a parametrised width counter with a phase FSM;
  - a terminal-count output and an advance input.

## Test plan
- Progressive mode, with `H_ACTIVE=8`, `H_FP=2`, `H_SYNC=3`, `H_BP=3`, `V_ACTIVE=4`, `V_FP=1`, `V_SYNC=2`, `V_BP=1`, `SYNC_POL=0`:
  - `hsync` is low for `x` 10–12;
  - `pclr` is seen at `x=15`;
  - `vsync` is low for `y` 5–6;
  - `cclr` occurs every 128 enabled cycles.
- Reset release, then `en=1`:
  - the first output cycle shows `x=0`, `y=0`, `frame_start=1`, `cblank=0`;
  - before that edge, `cblank=1`, `hsync=1` and `vsync=1`.
- `en` toggled 1010… over one line: all outputs advance only on cycles where `en=1`, and the line takes 32 clocks.
- `interlace=1` with the same parameters:
  - `field` alternates 0/1;
  - field 1 spans 9 lines (144 cycles);
  - field-1 vsync edges fall at `x=8`.
- Csync overlap: while both syncs are asserted (`y` 5–6, `x` 10–12), `csync` is high. During vsync outside hsync, `csync` is low.
- Reset at `x=5`, `y=2`: all outputs are at reset values immediately; the raster restarts at (0,0) with `frame_start=1`.
